// File: rtl/gcd_request_ctrl.sv
// gcd_request_ctrl
// Initiator side of the GCD start/done handshake. It sits between the board
// switches and the GCD wrapper. A rising start switch samples the operands and
// requests a computation from the core. The block then waits for the core's
// done and captures the result for the LEDs. Zero operands are answered
// locally, and a core that never answers ends in an error state.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_sw    raw start switch level (asynchronous to clk)
//   a_sw, b_sw  operands from the switches
//   gcd_a/gcd_b operands to the core, held while the request is open
//   gcd_start   request level to the core
//   gcd_done    completion from the core (level or pulse)
//   gcd_result  core result, valid while gcd_done is high
//   result_led  captured result
//   done_led    result_led holds a valid result
//   busy        request open (REQ or WAIT)
//   err         core timed out
module gcd_request_ctrl #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_sw,
    input  logic [WIDTH-1:0] a_sw,
    input  logic [WIDTH-1:0] b_sw,
    output logic [WIDTH-1:0] gcd_a,
    output logic [WIDTH-1:0] gcd_b,
    output logic             gcd_start,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic [WIDTH-1:0] result_led,
    output logic             done_led,
    output logic             busy,
    output logic             err
);

    // The counter only has to reach TIMEOUT-1.
    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SHOW = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic sync1;
    logic s_start;
    logic s_prev;
    logic done_prev;
    logic start_edge;
    logic done_rise;

    // Synchronizer and history flops reset high. Because of this, a start
    // switch or a done line that is already high when reset is released
    // looks like "no edge". A fresh low-to-high transition is then required.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            s_start   <= 1'b1;
            s_prev    <= 1'b1;
            done_prev <= 1'b1;
        end else begin
            sync1     <= start_sw;
            s_start   <= sync1;
            s_prev    <= s_start;
            done_prev <= gcd_done;
        end
    end

    assign start_edge = s_start & ~s_prev;
    assign done_rise  = gcd_done & ~done_prev;

    // Request state machine. All LED and core-facing outputs are registered.
    // gcd_start and busy are set on entry to REQ and cleared on leaving WAIT.
    // In WAIT, done_rise is tested before the timeout, so done_rise wins when
    // both happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            gcd_a      <= '0;
            gcd_b      <= '0;
            gcd_start  <= 1'b0;
            result_led <= '0;
            done_led   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        gcd_a <= a_sw;
                        gcd_b <= b_sw;
                        if (a_sw == '0 || b_sw == '0) begin
                            // gcd(0,x) = x and gcd(0,0) = 0, so OR gives the answer.
                            result_led <= a_sw | b_sw;
                            done_led   <= 1'b1;
                            state      <= ST_SHOW;
                        end else begin
                            done_led  <= 1'b0;
                            gcd_start <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    count <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_rise) begin
                        result_led <= gcd_result;
                        done_led   <= 1'b1;
                        gcd_start  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_SHOW;
                    end else if (count == CNT_LAST) begin
                        result_led <= '1;
                        err        <= 1'b1;
                        gcd_start  <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_ERR;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (!s_start) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (!s_start) begin
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gcd_start <= 1'b0;
                    busy      <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_request_ctrl.sv
// tb_gcd_request_ctrl
// Bench for gcd_request_ctrl. The bench plays the switches and the GCD core.
// Each transaction is scored against a transaction-level expectation:
//   - the kind of outcome (local zero answer, core answer, or timeout);
//   - the captured value;
//   - the cycle at which done_led or err appears, counted from the first
//     cycle where gcd_start is seen high.
module tb_gcd_request_ctrl;

    localparam int W   = 4;
    localparam int TMO = 16;

    logic         clk;
    logic         rst_n;
    logic         start_sw;
    logic [W-1:0] a_sw;
    logic [W-1:0] b_sw;
    logic [W-1:0] gcd_a;
    logic [W-1:0] gcd_b;
    logic         gcd_start;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic [W-1:0] result_led;
    logic         done_led;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    gcd_request_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_sw   (start_sw),
        .a_sw       (a_sw),
        .b_sw       (b_sw),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_start  (gcd_start),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .result_led (result_led),
        .done_led   (done_led),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         d;          // done raised d cycles after gcd_start seen; -1 = never
        bit         pulse;      // 1 = one-cycle done pulse, 0 = level until gcd_start drops
        bit         keep;       // leave done high after the transaction
        bit         stuck;      // do not touch done at all (stale high)
        bit         change_sw;  // wiggle the switches while the request is open
        logic [3:0] exp_res;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic st);
        a_sw     = a;
        b_sw     = b;
        start_sw = st;
    endtask

    function automatic logic [3:0] gcd_ref(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[3:0];
    endfunction

    // Outcome model: a zero operand is answered locally. Otherwise the core
    // answer counts only if a fresh done edge lands within the TMO WAIT cycles.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input int d, input bit stuck,
                         output logic [3:0] res, output bit dn, output bit er);
        if (a == 0 || b == 0) begin
            res = a | b; dn = 1'b1; er = 1'b0;
        end else if (stuck || d < 1 || d > TMO) begin
            res = 4'hF; dn = 1'b0; er = 1'b1;
        end else begin
            res = gcd_ref(a, b); dn = 1'b1; er = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  first_start;
        int  first_done;
        int  first_err;
        int  starts;
        bit  prev_gs;
        bit  ops_bad;
        bit  nonzero;
        logic [3:0] res;
        nonzero     = (v.a != 0) && (v.b != 0);
        res         = gcd_ref(v.a, v.b);
        first_start = -1;
        first_done  = -1;
        first_err   = -1;
        starts      = 0;
        prev_gs     = 1'b0;
        ops_bad     = 1'b0;

        applyStimulus(v.a, v.b, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(v.a, v.b, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (gcd_start && !prev_gs) starts++;
            prev_gs = gcd_start;
            if (gcd_start && first_start < 0) first_start = i;
            if (first_start >= 0) break;
        end

        if (nonzero) begin
            checkOutput("start_latency", first_start,
                        (first_start >= 3 && first_start <= 4) ? first_start : 3);
            if (first_start < 0) begin
                start_sw = 1'b0;
                return;
            end
            checkOutput("req_gcd_a", int'(gcd_a), int'(v.a));
            checkOutput("req_gcd_b", int'(gcd_b), int'(v.b));
            checkOutput("req_busy", int'(busy), 1);
            checkOutput("req_done_led_clr", int'(done_led), 0);
            if (v.change_sw) begin
                a_sw = ~v.a;
                b_sw = v.a ^ v.b ^ 4'h5;
            end
            if (!v.stuck) begin
                gcd_done   = (v.d == 0);
                gcd_result = res;
            end
            for (int k = 1; k <= TMO + 3; k++) begin
                @(negedge clk);
                if (gcd_start && !prev_gs) starts++;
                prev_gs = gcd_start;
                if (done_led && first_done < 0) first_done = k;
                if (err && first_err < 0) first_err = k;
                if (busy !== gcd_start) ops_bad = 1'b1;
                if (busy && (gcd_a !== v.a || gcd_b !== v.b)) ops_bad = 1'b1;
                if (!v.stuck) begin
                    if (k == v.d) gcd_done = 1'b1;
                    else if (v.pulse && k == v.d + 1) gcd_done = 1'b0;
                    else if (!v.pulse && !v.keep && gcd_done && !gcd_start && k > v.d) gcd_done = 1'b0;
                end
            end
            checkOutput("request_count", starts, 1);
            checkOutput("ops_stable_busy", int'(ops_bad), 0);
            if (v.exp_err) begin
                checkOutput("err_cycle", first_err, TMO + 1);
                checkOutput("no_done_led", first_done, -1);
            end else begin
                checkOutput("done_led_cycle", first_done, v.d + 1);
                checkOutput("no_err", first_err, -1);
            end
        end else begin
            checkOutput("zero_no_request", starts, 0);
        end

        checkOutput("result_led", int'(result_led), int'(v.exp_res));
        checkOutput("done_led", int'(done_led), int'(v.exp_done));
        checkOutput("err", int'(err), int'(v.exp_err));
        checkOutput("gcd_start_end", int'(gcd_start), 0);
        checkOutput("busy_end", int'(busy), 0);
        checkOutput("gcd_a_held", int'(gcd_a), int'(v.a));
        checkOutput("gcd_b_held", int'(gcd_b), int'(v.b));

        // Lowering start returns to IDLE. err clears, but the LEDs keep their values.
        start_sw = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("idle_err", int'(err), 0);
        checkOutput("idle_done_led", int'(done_led), int'(v.exp_done));
        checkOutput("idle_result_led", int'(result_led), int'(v.exp_res));
    endtask

    initial begin
        vec_t       v;
        logic [3:0] r;
        bit         dn;
        bit         er;
        bit         bad;
        bit         found;

        //           a      b      d   pul keep stk chg  res    dn er
        vecs[0]  = '{4'd12, 4'd8,  10, 0,  0,   0,  0,   4'd4,  1, 0};
        vecs[1]  = '{4'd0,  4'd9,  0,  0,  0,   0,  0,   4'd9,  1, 0};
        vecs[2]  = '{4'd0,  4'd0,  0,  0,  0,   0,  0,   4'd0,  1, 0};
        vecs[3]  = '{4'd5,  4'd0,  0,  0,  0,   0,  0,   4'd5,  1, 0};
        vecs[4]  = '{4'd9,  4'd6,  1,  1,  0,   0,  0,   4'd3,  1, 0};
        vecs[5]  = '{4'd15, 4'd10, 16, 1,  0,   0,  0,   4'd5,  1, 0};
        vecs[6]  = '{4'd7,  4'd7,  17, 0,  0,   0,  0,   4'hF,  0, 1};
        vecs[7]  = '{4'd8,  4'd4,  0,  0,  0,   0,  0,   4'hF,  0, 1};
        vecs[8]  = '{4'd14, 4'd7,  5,  0,  0,   0,  1,   4'd7,  1, 0};
        vecs[9]  = '{4'd13, 4'd11, -1, 0,  0,   0,  0,   4'hF,  0, 1};
        vecs[10] = '{4'd3,  4'd9,  3,  0,  0,   0,  0,   4'd3,  1, 0};

        // Reset with the start switch already high.
        rst_n      = 1'b0;
        gcd_done   = 1'b0;
        gcd_result = '0;
        applyStimulus(4'd12, 4'd8, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_gcd_start", int'(gcd_start), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_err", int'(err), 0);
        checkOutput("rst_done_led", int'(done_led), 0);
        checkOutput("rst_result_led", int'(result_led), 0);
        checkOutput("rst_gcd_a", int'(gcd_a), 0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (gcd_start || busy || done_led) bad = 1'b1;
        end
        checkOutput("held_start_no_request", int'(bad), 0);

        for (int i = 0; i < 11; i++) run_txn(vecs[i]);

        // A level done held across two requests must not satisfy the second one.
        run_txn('{4'd12, 4'd8, 4, 0, 1, 0, 1, 4'd4, 1, 0});
        run_txn('{4'd6, 4'd9, 0, 0, 0, 1, 0, 4'hF, 0, 1});
        run_txn('{4'd6, 4'd9, 2, 0, 0, 0, 0, 4'd3, 1, 0});

        // Reset in the middle of WAIT clears outputs without a clock edge.
        applyStimulus(4'd3, 4'd6, 1'b0);
        repeat (4) @(negedge clk);
        applyStimulus(4'd3, 4'd6, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (gcd_start) found = 1'b1;
        end
        checkOutput("midrst_request_seen", int'(found), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_gcd_start", int'(gcd_start), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_result_led", int'(result_led), 0);
        checkOutput("midrst_done_led", int'(done_led), 0);
        checkOutput("midrst_gcd_a", int'(gcd_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn('{4'd3, 4'd6, 4, 0, 0, 0, 0, 4'd3, 1, 0});

        // Randomized transactions scored by the outcome model.
        for (int n = 0; n < 30; n++) begin
            v.a         = 4'($urandom_range(0, 15));
            v.b         = 4'($urandom_range(0, 15));
            v.d         = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO + 2));
            v.pulse     = 1'($urandom_range(0, 1));
            v.keep      = 1'b0;
            v.stuck     = 1'b0;
            v.change_sw = 1'($urandom_range(0, 1));
            model(v.a, v.b, v.d, v.stuck, r, dn, er);
            v.exp_res  = r;
            v.exp_done = dn;
            v.exp_err  = er;
            run_txn(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
